com_bus_mem_responder: RTL and testbench

- Responder end of the common coherence bus that the per-core cache wrappers drive as initiators (Com_Bus_Req_proc / Com_Bus_Gnt_proc / Address_Com / Data_Bus_Com / Data_in_Bus).
- Arbitrates round-robin among N_REQ cache requesters and grants the bus to one at a time.
- Gives a snooping cache a window to supply data; if none does, serves the read from the main-memory array or commits a write-back.
- Sits at top level between the 4-core cache wrappers and main memory; one instance per system.

---
 rtl/com_bus_mem_responder_pkg.sv | 24 ++
 rtl/com_bus_rr_arbiter.sv | 31 +++
 rtl/com_bus_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_com_bus_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_bus_mem_responder_pkg.sv
// Shared definitions for the coherence-bus memory responder: FSM encoding,
// default bus width and the round-robin pointer helper.
package com_bus_mem_responder_pkg;

   localparam int ADDRESSSIZE = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_SNOOP   = 3'd2,
      ST_MEM     = 3'd3,
      ST_DRIVE   = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/com_bus_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around, returned both one-hot and as an index.
module com_bus_rr_arbiter #(
   parameter  int N_REQ = 8,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_vld
);

   logic [IDX_W-1:0] w_cand;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_vld  = 1'b0;
      w_cand = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
         if (!o_vld && i_req[w_cand]) begin
            o_vld         = 1'b1;
            o_idx         = w_cand;
            o_gnt[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/com_bus_mem_responder.sv
// Responder end of the common coherence bus: grants one cache at a time,
// lets snoopers supply read data, otherwise serves reads / commits write-backs.
module com_bus_mem_responder
   import com_bus_mem_responder_pkg::*;
#(
   parameter int ADDR_W    = ADDRESSSIZE,
   parameter int N_REQ     = 8,
   parameter int MEM_AW    = 10,
   parameter int MEM_LAT   = 4,
   parameter int SNOOP_WIN = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  Com_Bus_Req,
   output logic [N_REQ-1:0]  Com_Bus_Gnt,
   input  logic              Com_Bus_Wr,
   input  logic [ADDR_W-1:0] Address_Com_in,
   input  logic [ADDR_W-1:0] Data_Bus_Com_in,
   output logic [ADDR_W-1:0] Data_Bus_Com_out,
   output logic              Data_Bus_Com_oe,
   input  logic              Data_in_Bus_in,
   output logic              Data_in_Bus_oe,
   output logic              Busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(max2(SNOOP_WIN, MEM_LAT) + 1);

   state_t             r_state, w_state_nxt;
   logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [MEM_AW-1:0]  r_addr;
   logic [ADDR_W-1:0]  r_data;
   logic [ADDR_W-1:0]  r_mem [0:(1<<MEM_AW)-1];

   logic [N_REQ-1:0]   w_arb_gnt;
   logic [IDX_W-1:0]   w_arb_idx;
   logic               w_arb_vld;
   logic               w_req_held;
   logic               w_release;
   logic               w_drive;
   logic               w_unused;

   // Only the low MEM_AW address bits select a memory word.
   assign w_unused = ^Address_Com_in[ADDR_W-1:MEM_AW];

   com_bus_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .i_req (Com_Bus_Req),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_vld (w_arb_vld)
   );

   assign w_req_held = Com_Bus_Req[r_idx];

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_idx_nxt   = r_idx;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_release   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_vld) begin
               w_gnt_nxt   = w_arb_gnt;
               w_idx_nxt   = w_arb_idx;
               w_state_nxt = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (Com_Bus_Wr) begin
               w_state_nxt = ST_RELEASE;
            end else begin
               w_state_nxt = ST_SNOOP;
               w_cnt_nxt   = '0;
            end
         end
         ST_SNOOP: begin
            if (!w_req_held) begin
               w_release = 1'b1;
            end else if (Data_in_Bus_in) begin
               w_state_nxt = ST_RELEASE;
            end else if (r_cnt == CNT_W'(SNOOP_WIN - 1)) begin
               w_state_nxt = ST_MEM;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_MEM: begin
            if (!w_req_held) begin
               w_release = 1'b1;
            end else if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
               w_state_nxt = ST_DRIVE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_DRIVE: begin
            if (!w_req_held) begin
               w_release = 1'b1;
            end else begin
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!w_req_held) begin
               w_release = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
      // Dropping the granted request ends the transaction from any post-address state.
      if (w_release) begin
         w_state_nxt = ST_IDLE;
         w_gnt_nxt   = '0;
         w_ptr_nxt   = IDX_W'(rr_next(int'(r_idx), N_REQ));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_idx   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_idx   <= w_idx_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Memory array and read path are data-only and deliberately not reset.
   always_ff @(posedge clk) begin
      if (r_state == ST_ADDR) begin
         r_addr <= Address_Com_in[MEM_AW-1:0];
         if (Com_Bus_Wr) begin
            r_mem[Address_Com_in[MEM_AW-1:0]] <= Data_Bus_Com_in;
         end
      end
      if (r_state == ST_MEM) begin
         r_data <= r_mem[r_addr];
      end
   end

   assign w_drive          = (r_state == ST_DRIVE) && w_req_held;
   assign Com_Bus_Gnt      = r_gnt;
   assign Data_Bus_Com_oe  = w_drive;
   assign Data_in_Bus_oe   = w_drive;
   assign Data_Bus_Com_out = w_drive ? r_data : '0;
   assign Busy             = (r_state != ST_IDLE);

endmodule

// File: tb/tb_com_bus_mem_responder.sv
// Directed bench for com_bus_mem_responder with a queue-based scoreboard:
// stimulus pushes expected grants / read data, a negedge monitor pops and compares.
module tb_com_bus_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  Com_Bus_Req = '0;
   logic [7:0]  Com_Bus_Gnt;
   logic        Com_Bus_Wr = 1'b0;
   logic [31:0] Address_Com_in = '0;
   logic [31:0] Data_Bus_Com_in = '0;
   logic [31:0] Data_Bus_Com_out;
   logic        Data_Bus_Com_oe;
   logic        Data_in_Bus_in = 1'b0;
   logic        Data_in_Bus_oe;
   logic        Busy;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_gnt_q[$];
   logic [31:0] exp_data_q[$];
   logic [7:0]  prev_gnt = '0;
   logic [7:0]  mon_g;
   logic [31:0] mon_d;

   com_bus_mem_responder dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .Com_Bus_Req      (Com_Bus_Req),
      .Com_Bus_Gnt      (Com_Bus_Gnt),
      .Com_Bus_Wr       (Com_Bus_Wr),
      .Address_Com_in   (Address_Com_in),
      .Data_Bus_Com_in  (Data_Bus_Com_in),
      .Data_Bus_Com_out (Data_Bus_Com_out),
      .Data_Bus_Com_oe  (Data_Bus_Com_oe),
      .Data_in_Bus_in   (Data_in_Bus_in),
      .Data_in_Bus_oe   (Data_in_Bus_oe),
      .Busy             (Busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every data drive and every new grant must match the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (Data_Bus_Com_oe) begin
            if (exp_data_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_drive actual=0x%0h required=no_drive", Data_Bus_Com_out);
            end else begin
               mon_d = exp_data_q.pop_front();
               check("read_data", Data_Bus_Com_out, mon_d);
               check("din_oe_with_data", 32'(Data_in_Bus_oe), 32'd1);
            end
         end
         if (Com_Bus_Gnt != 8'h00 && prev_gnt == 8'h00) begin
            if (exp_gnt_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_grant actual=0x%0h required=none", Com_Bus_Gnt);
            end else begin
               mon_g = exp_gnt_q.pop_front();
               check("grant_order", 32'(Com_Bus_Gnt), 32'(mon_g));
            end
         end
      end
      prev_gnt = Com_Bus_Gnt;
   end

   task automatic do_reset();
      rst_n = 1'b0;
      Com_Bus_Req = '0;
      Com_Bus_Wr = 1'b0;
      Data_in_Bus_in = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_gnt(input int idx);
      int n = 0;
      while (Com_Bus_Gnt[3'(idx)] !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (Com_Bus_Gnt[3'(idx)] !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL grant_timeout actual=0x%0h required_idx=%0d", Com_Bus_Gnt, idx);
      end
   endtask

   task automatic wait_any(output int g, output int n);
      n = 0;
      g = 0;
      while (Com_Bus_Gnt == 8'h00 && n < 20) begin
         tick();
         n++;
      end
      if (Com_Bus_Gnt == 8'h00) begin
         checks++;
         failures++;
         $display("FAIL grant_any_timeout actual=0x00 required=nonzero");
      end
      for (int b = 0; b < 8; b++) if (Com_Bus_Gnt[b]) g = b;
   endtask

   task automatic write_txn(input int idx, input logic [31:0] addr, input logic [31:0] data);
      exp_gnt_q.push_back(8'(1 << idx));
      Com_Bus_Wr = 1'b1;
      Address_Com_in = addr;
      Data_Bus_Com_in = data;
      Com_Bus_Req[3'(idx)] = 1'b1;
      wait_gnt(idx);
      tick();
      check("wr_busy_release", 32'(Busy), 32'd1);
      Com_Bus_Req[3'(idx)] = 1'b0;
      Com_Bus_Wr = 1'b0;
      tick();
      check("wr_gnt_idle", 32'(Com_Bus_Gnt), 32'd0);
      check("wr_busy_idle", 32'(Busy), 32'd0);
   endtask

   // snoop_cyc = 0: memory serves; snoop_cyc = k: a cache raises Data_in_Bus in SNOOP cycle k.
   task automatic read_txn(input int idx, input logic [31:0] addr, input logic [31:0] exp,
                           input int snoop_cyc);
      int gnt_c = 0;
      int oe_cnt = 0;
      int oe_c = 0;
      exp_gnt_q.push_back(8'(1 << idx));
      if (snoop_cyc == 0) exp_data_q.push_back(exp);
      Com_Bus_Wr = 1'b0;
      Address_Com_in = addr;
      Data_Bus_Com_in = 32'hBAD0_BAD0;
      Com_Bus_Req[3'(idx)] = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         Data_in_Bus_in = (snoop_cyc != 0) && (c == 1 + snoop_cyc);
         if (Com_Bus_Gnt[3'(idx)] && gnt_c == 0) gnt_c = c;
         if (Data_Bus_Com_oe) begin
            oe_cnt++;
            if (oe_c == 0) oe_c = c;
         end
      end
      check("rd_gnt_latency", 32'(gnt_c), 32'd1);
      check("rd_gnt_value", 32'(Com_Bus_Gnt), 32'(8'(1 << idx)));
      check("rd_oe_cycles", 32'(oe_cnt), (snoop_cyc == 0) ? 32'd1 : 32'd0);
      if (snoop_cyc == 0) check("rd_oe_cycle_index", 32'(oe_c), 32'd8);
      check("rd_busy_release", 32'(Busy), 32'd1);
      Com_Bus_Req[3'(idx)] = 1'b0;
      tick();
      check("rd_gnt_idle", 32'(Com_Bus_Gnt), 32'd0);
      check("rd_busy_idle", 32'(Busy), 32'd0);
   endtask

   // Serves n write grants from whatever requests are up; optionally re-raises each served request.
   task automatic serve(input int n_grants, input bit reraise);
      int g;
      int n;
      for (int k = 0; k < n_grants; k++) begin
         wait_any(g, n);
         check("rr_req_to_gnt", 32'(n), 32'd1);
         tick();
         Com_Bus_Req[3'(g)] = 1'b0;
         tick();
         check("rr_idle_gap", 32'(Com_Bus_Gnt), 32'd0);
         if (reraise) Com_Bus_Req[3'(g)] = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_gnt", 32'(Com_Bus_Gnt), 32'd0);
      check("rst_data_oe", 32'(Data_Bus_Com_oe), 32'd0);
      check("rst_din_oe", 32'(Data_in_Bus_oe), 32'd0);
      check("rst_data_out", Data_Bus_Com_out, 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      do_reset();

      // Plain read served by memory, then a snoop-hit read that must never drive.
      write_txn(2, 32'h10, 32'hDEAD_BEEF);
      read_txn(2, 32'h10, 32'hDEAD_BEEF, 0);
      read_txn(1, 32'h20, 32'h0, 2);

      // Write-back followed by read-back.
      write_txn(5, 32'h30, 32'h1234_5678);
      read_txn(5, 32'h30, 32'h1234_5678, 0);
      read_txn(2, 32'h10, 32'hDEAD_BEEF, 0);

      // Round-robin between idx0 and idx7 from pointer 0.
      do_reset();
      exp_gnt_q.push_back(8'h01);
      exp_gnt_q.push_back(8'h80);
      exp_gnt_q.push_back(8'h01);
      Com_Bus_Wr = 1'b1;
      Address_Com_in = 32'h40;
      Data_Bus_Com_in = 32'h0000_0055;
      Com_Bus_Req = 8'b1000_0001;
      serve(3, 1'b1);
      Com_Bus_Req = '0;
      tick();

      // Pointer wrap: serve idx6 so the pointer sits at 7, then idx0 before idx1.
      do_reset();
      write_txn(6, 32'h44, 32'h0000_0066);
      exp_gnt_q.push_back(8'h01);
      exp_gnt_q.push_back(8'h02);
      Com_Bus_Wr = 1'b1;
      Com_Bus_Req = 8'b0000_0011;
      serve(2, 1'b0);
      Com_Bus_Req = '0;
      Com_Bus_Wr = 1'b0;
      tick();

      // Reset in MEM with the pointer at 6: afterwards req3 must win over req6.
      do_reset();
      write_txn(5, 32'h50, 32'h0000_0001);
      exp_gnt_q.push_back(8'h40);
      Com_Bus_Wr = 1'b0;
      Address_Com_in = 32'h10;
      Com_Bus_Req = 8'b0100_1000;
      for (int c = 1; c <= 5; c++) tick();
      check("pre_reset_gnt", 32'(Com_Bus_Gnt), 32'h40);
      check("pre_reset_busy", 32'(Busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_gnt", 32'(Com_Bus_Gnt), 32'd0);
      check("midrst_data_oe", 32'(Data_Bus_Com_oe), 32'd0);
      check("midrst_din_oe", 32'(Data_in_Bus_oe), 32'd0);
      check("midrst_busy", 32'(Busy), 32'd0);
      exp_gnt_q.push_back(8'h08);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_gnt", 32'(Com_Bus_Gnt), 32'h08);
      Com_Bus_Req = '0;
      tick();
      tick();
      check("abort_gnt_idle", 32'(Com_Bus_Gnt), 32'd0);
      check("abort_busy_idle", 32'(Busy), 32'd0);
      tick();

      check("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
      check("data_queue_empty", 32'(exp_data_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
